// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg: shared types, segment patterns and the BCD-to-7-segment
// decoder for the digit_scan_counter slice.
//   bcd_t      : one BCD decade, always 0..9
//   seg_t      : segments {g,f,e,d,c,b,a}, active-high
//   seg_decode : BCD digit -> segment pattern (blank for non-BCD codes)
package digit_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t PAT_BLANK = 7'h00;
  localparam seg_t PAT_0     = 7'h3F;
  localparam seg_t PAT_1     = 7'h06;
  localparam seg_t PAT_2     = 7'h5B;
  localparam seg_t PAT_3     = 7'h4F;
  localparam seg_t PAT_4     = 7'h66;
  localparam seg_t PAT_5     = 7'h6D;
  localparam seg_t PAT_6     = 7'h7D;
  localparam seg_t PAT_7     = 7'h07;
  localparam seg_t PAT_8     = 7'h7F;
  localparam seg_t PAT_9     = 7'h6F;

  function automatic seg_t seg_decode(input bcd_t d);
    seg_t s;
    case (d)
      4'd0:    s = PAT_0;
      4'd1:    s = PAT_1;
      4'd2:    s = PAT_2;
      4'd3:    s = PAT_3;
      4'd4:    s = PAT_4;
      4'd5:    s = PAT_5;
      4'd6:    s = PAT_6;
      4'd7:    s = PAT_7;
      4'd8:    s = PAT_8;
      4'd9:    s = PAT_9;
      default: s = PAT_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// bcd_decade: one BCD counter decade with combinational carry-out, so a
// chain of decades ripples a full carry within a single clock.
//   CLK   : clock
//   RST   : synchronous active-high reset (digit -> 0)
//   clr   : synchronous clear (digit -> 0), wins over cin
//   cin   : increment request from the lower decade
//   digit : current decade value, 0..9
//   cout  : cin AND digit == 9 (this decade wraps on this edge)
module bcd_decade
  import digit_scan_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic cin,
  output bcd_t digit,
  output logic cout
);

  assign cout = cin && (digit == 4'd9);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      digit <= '0;
    end else if (cin) begin
      digit <= (digit == 4'd9) ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/digit_scan_counter.sv
// digit_scan_counter: four-decade BCD event counter with a time-multiplexed
// 7-segment output strobed by an upstream 4-phase one-hot ring counter.
//   CLK, RST      : clock, synchronous active-high reset
//   PH_0..PH_3    : one-hot scan phase, PH_k selects decade k (0 = units)
//   EVT           : asynchronous event input, counted once per rising edge
//   CLR           : synchronous clear of count, OVF and ERR
//   SEG_0..SEG_6  : registered segments a..g, active-high
//   OVF           : sticky 9999 -> 0000 wrap flag
//   ERR           : sticky flag for a phase that was not one-hot
// Parameters: SYNC_STAGES (2..3) synchronizer depth, LZB leading-zero blanking.
module digit_scan_counter
  import digit_scan_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          LZB         = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic PH_0,
  input  logic PH_1,
  input  logic PH_2,
  input  logic PH_3,
  input  logic EVT,
  input  logic CLR,
  output logic SEG_0,
  output logic SEG_1,
  output logic SEG_2,
  output logic SEG_3,
  output logic SEG_4,
  output logic SEG_5,
  output logic SEG_6,
  output logic OVF,
  output logic ERR
);

  logic [SYNC_STAGES-1:0] syncFf;
  logic [SYNC_STAGES-1:0] syncVld;
  logic                   evtHist;
  logic                   inc;

  // Reset zeroes the synchronizer, so EVT held high across reset release
  // would otherwise look like a fresh 0->1 edge. syncVld marks which stages
  // hold a real post-reset sample; history reads as "high" until the last
  // stage is valid, so only an edge observed after release is counted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      syncFf  <= '0;
      syncVld <= '0;
      evtHist <= 1'b1;
    end else begin
      syncFf  <= {syncFf[SYNC_STAGES-2:0], EVT};
      syncVld <= {syncVld[SYNC_STAGES-2:0], 1'b1};
      evtHist <= syncVld[SYNC_STAGES-1] ? syncFf[SYNC_STAGES-1] : 1'b1;
    end
  end

  assign inc = syncVld[SYNC_STAGES-1] && syncFf[SYNC_STAGES-1] && !evtHist;

  bcd_t                digits [NUM_DIGITS];
  logic [NUM_DIGITS:0] carry;

  assign carry[0] = inc;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDecade
    bcd_decade uDecade (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (CLR),
      .cin   (carry[i]),
      .digit (digits[i]),
      .cout  (carry[i+1])
    );
  end

  // A decade is blanked when it and every higher decade are zero.
  logic [NUM_DIGITS-1:0] blank;

  always_comb begin
    blank    = '0;
    blank[3] = LZB && (digits[3] == '0);
    blank[2] = blank[3] && (digits[2] == '0);
    blank[1] = blank[2] && (digits[1] == '0);
  end

  seg_t digitSeg [NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDecode
    assign digitSeg[i] = blank[i] ? PAT_BLANK : seg_decode(digits[i]);
  end

  logic [3:0] ph;
  logic       phOneHot;
  seg_t       segNext;
  seg_t       segReg;

  assign ph       = {PH_3, PH_2, PH_1, PH_0};
  assign phOneHot = $onehot(ph);

  always_comb begin
    segNext = PAT_BLANK;
    case (ph)
      4'b0001: segNext = digitSeg[0];
      4'b0010: segNext = digitSeg[1];
      4'b0100: segNext = digitSeg[2];
      4'b1000: segNext = digitSeg[3];
      default: segNext = PAT_BLANK;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      segReg <= '0;
      OVF    <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      segReg <= segNext;
      if (CLR) begin
        OVF <= 1'b0;
        ERR <= 1'b0;
      end else begin
        if (carry[NUM_DIGITS]) OVF <= 1'b1;
        if (!phOneHot)         ERR <= 1'b1;
      end
    end
  end

  assign {SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0} = segReg;

endmodule

// File: tb/tb_digit_scan_counter.sv
module tb_digit_scan_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       evt = 1'b0;
  logic [3:0] ph  = 4'b0001;

  logic [6:0] segA, segB;
  logic       ovfA, errA, ovfB, errB;

  digit_scan_counter #(.SYNC_STAGES(2), .LZB(1'b0)) dut (
    .CLK(clk), .RST(rst), .PH_0(ph[0]), .PH_1(ph[1]), .PH_2(ph[2]), .PH_3(ph[3]),
    .EVT(evt), .CLR(clr),
    .SEG_0(segA[0]), .SEG_1(segA[1]), .SEG_2(segA[2]), .SEG_3(segA[3]),
    .SEG_4(segA[4]), .SEG_5(segA[5]), .SEG_6(segA[6]),
    .OVF(ovfA), .ERR(errA)
  );

  digit_scan_counter #(.SYNC_STAGES(2), .LZB(1'b1)) dutLzb (
    .CLK(clk), .RST(rst), .PH_0(ph[0]), .PH_1(ph[1]), .PH_2(ph[2]), .PH_3(ph[3]),
    .EVT(evt), .CLR(clr),
    .SEG_0(segB[0]), .SEG_1(segB[1]), .SEG_2(segB[2]), .SEG_3(segB[3]),
    .SEG_4(segB[4]), .SEG_5(segB[5]), .SEG_6(segB[6]),
    .OVF(ovfB), .ERR(errB)
  );

  int assertCnt = 0;
  int failCnt   = 0;

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    bit         chk;
    string      tag;
    logic [6:0] segA;
    logic [6:0] segB;
    logic       ovf;
    logic       err;
  } expEntry_t;

  expEntry_t sb [$];

  int   mCount = 0;
  logic mOvf   = 1'b0;
  logic mErr   = 1'b0;

  task automatic checkEq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit isOneHot(input logic [3:0] p);
    return (p == 4'b0001) || (p == 4'b0010) || (p == 4'b0100) || (p == 4'b1000);
  endfunction

  function automatic logic [6:0] expSeg(input int cnt, input logic [3:0] p, input bit lzb);
    int k;
    int pw;
    case (p)
      4'b0001: k = 0;
      4'b0010: k = 1;
      4'b0100: k = 2;
      4'b1000: k = 3;
      default: return 7'h00;
    endcase
    pw = 10 ** k;
    if (lzb && k > 0 && cnt < pw) return 7'h00;
    return pats[(cnt / pw) % 10];
  endfunction

  // Drive one cycle of inputs, predict outputs after the edge, compare.
  task automatic step(input logic [3:0] p, input logic e, input logic c,
                      input logic r, input bit chk, input string tag);
    expEntry_t x;
    ph = p; evt = e; clr = c; rst = r;
    x.chk = chk;
    x.tag = tag;
    if (r) begin
      x.segA = 7'h00;
      x.segB = 7'h00;
      mCount = 0; mOvf = 1'b0; mErr = 1'b0;
    end else begin
      x.segA = expSeg(mCount, p, 1'b0);
      x.segB = expSeg(mCount, p, 1'b1);
      if (c) begin
        mCount = 0; mOvf = 1'b0; mErr = 1'b0;
      end else if (!isOneHot(p)) begin
        mErr = 1'b1;
      end
    end
    x.ovf = mOvf;
    x.err = mErr;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    if (x.chk) begin
      checkEq({x.tag, ".seg"},    segA,           x.segA);
      checkEq({x.tag, ".segLzb"}, segB,           x.segB);
      checkEq({x.tag, ".ovf"},    {6'b0, ovfA},   {6'b0, x.ovf});
      checkEq({x.tag, ".err"},    {6'b0, errA},   {6'b0, x.err});
      checkEq({x.tag, ".ovfLzb"}, {6'b0, ovfB},   {6'b0, x.ovf});
      checkEq({x.tag, ".errLzb"}, {6'b0, errB},   {6'b0, x.err});
    end
  endtask

  task automatic countPulse(input int hi, input int lo);
    repeat (hi) step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, "pulse");
    repeat (lo) step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, "pulse");
    mCount++;
    if (mCount == 10000) begin
      mCount = 0;
      mOvf   = 1'b1;
    end
  endtask

  task automatic scan(input logic e, input string tag);
    for (int k = 0; k < 4; k++) step(4'b0001 << k, e, 1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    #1;
    step(4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, "reset0");
    step(4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, "reset1");
    scan(1'b0, "idle");

    repeat (3) countPulse(4, 4);
    scan(1'b0, "count3");

    repeat (9996) countPulse(2, 2);
    scan(1'b0, "full");
    countPulse(4, 4);
    scan(1'b0, "wrap");
    scan(1'b0, "ovfHold");
    step(4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, "clrOvf");
    step(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, "afterClrOvf");

    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, "phZero");
    step(4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, "phTwo");
    step(4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, "clrErr");
    step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, "afterClrErr");

    repeat (5) countPulse(4, 4);
    scan(1'b0, "count5");
    step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, "incE0");
    step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, "incE1");
    step(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, "clrInc");
    repeat (4) step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, "clrIncHold");
    repeat (4) step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, "clrIncLow");
    scan(1'b0, "afterClrInc");

    repeat (42) countPulse(2, 2);
    scan(1'b0, "count42");
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, "preErr");
    step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, "evtHigh");
    step(4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, "midRst");
    step(4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, "midRst2");
    scan(1'b1, "rstRelease");
    scan(1'b1, "rstReleaseHold");
    repeat (4) step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, "evtLow");
    countPulse(4, 4);
    scan(1'b0, "freshEdge");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
